// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_mem_pkg: state encoding and constants for riscv_mem_responder |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_FETCH_RSP = 3'd1,
    S_DECIDE    = 3'd2,
    S_DATA      = 3'd3,
    S_DATA_RSP  = 3'd4,
    S_COMMIT    = 3'd5
  } state_t;

  localparam logic [31:0] c_NOP         = 32'h0000_0013;
  localparam logic [6:0]  c_OPCODE_LOAD = 7'b0000011;

endpackage
`default_nettype wire

// File: rtl/riscv_mem_perf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_mem_perf: committed-instruction and SRAM wait-state counters |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module riscv_mem_perf (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_commit,
  input  logic        I_wait,
  output logic [31:0] O_instret,
  output logic [31:0] O_wait_cycles
);

  logic [31:0] r_instret;
  logic [31:0] r_wait_cycles;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_instret     <= '0;
      r_wait_cycles <= '0;
    end else begin
      if (I_commit) r_instret     <= r_instret + 32'd1;
      if (I_wait)   r_wait_cycles <= r_wait_cycles + 32'd1;
    end
  end

  assign O_instret     = r_instret;
  assign O_wait_cycles = r_wait_cycles;

endmodule
`default_nettype wire

// File: rtl/riscv_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_mem_responder: serves core imem/dmem from one SRAM, stalls   |
// | the core until commit. Counters built only with RISCV_MEM_PERF_EN. |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int          ADDR_W        = 14,
  parameter logic [31:0] RESET_PC_WORD = 32'd0
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [31:0]       I_imem_addr,
  output logic [31:0]       O_imem_data,
  input  logic [31:0]       I_dmem_addr,
  input  logic [31:0]       I_dmem_wdata,
  input  logic [3:0]        I_dmem_wmask,
  input  logic              I_dmem_we,
  input  logic              I_dmem_re,
  output logic [31:0]       O_dmem_rdata,
  output logic              O_stall,
  output logic              O_mem_en,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [3:0]        O_mem_wmask,
  output logic [31:0]       O_mem_wdata,
  input  logic              I_mem_ready,
  input  logic [31:0]       I_mem_rdata,
  output logic [31:0]       O_instret,
  output logic [31:0]       O_wait_cycles
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_is_write;
  logic              w_is_write_nxt;
  logic [31:0]       r_imem_data;
  logic [31:0]       r_dmem_rdata;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [3:0]        w_mem_wmask;
  logic [31:0]       w_mem_wdata;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state      <= S_FETCH;
      r_is_write   <= 1'b0;
      r_imem_data  <= c_NOP;
      r_dmem_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_is_write <= w_is_write_nxt;
      if (r_state == S_FETCH_RSP) r_imem_data  <= I_mem_rdata;
      if (r_state == S_DATA_RSP)  r_dmem_rdata <= I_mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_is_write_nxt = r_is_write;
    w_mem_en       = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = '0;
    w_mem_wmask    = '0;
    w_mem_wdata    = '0;
    case (r_state)
      S_FETCH: begin
        w_mem_en   = 1'b1;
        w_mem_addr = I_imem_addr[ADDR_W+1:2];
        if (I_mem_ready) w_state_nxt = S_FETCH_RSP;
      end
      S_FETCH_RSP: w_state_nxt = S_DECIDE;
      S_DECIDE: begin
        // Store wins over load; an all-zero mask store commits without touching the SRAM
        if (I_dmem_we) begin
          w_is_write_nxt = 1'b1;
          w_state_nxt    = (I_dmem_wmask != 4'b0000) ? S_DATA : S_COMMIT;
        end else if (I_dmem_re) begin
          w_is_write_nxt = 1'b0;
          w_state_nxt    = S_DATA;
        end else begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_DATA: begin
        w_mem_en   = 1'b1;
        w_mem_we   = r_is_write;
        w_mem_addr = I_dmem_addr[ADDR_W+1:2];
        if (r_is_write) begin
          w_mem_wmask = I_dmem_wmask;
          w_mem_wdata = I_dmem_wdata;
        end
        if (I_mem_ready) w_state_nxt = r_is_write ? S_COMMIT : S_DATA_RSP;
      end
      S_DATA_RSP: w_state_nxt = S_COMMIT;
      S_COMMIT:   w_state_nxt = S_FETCH;
      default:    w_state_nxt = S_FETCH;
    endcase
  end

  // The reset state is itself an access state, so the SRAM side is held quiet while in reset
  assign O_mem_en    = w_mem_en & I_rst_n;
  assign O_mem_we    = w_mem_we & I_rst_n;
  assign O_mem_addr  = I_rst_n ? w_mem_addr  : '0;
  assign O_mem_wmask = I_rst_n ? w_mem_wmask : '0;
  assign O_mem_wdata = I_rst_n ? w_mem_wdata : '0;

  assign O_stall      = (r_state != S_COMMIT);
  assign O_imem_data  = r_imem_data;
  assign O_dmem_rdata = r_dmem_rdata;

`ifdef RISCV_MEM_PERF_EN
  logic w_commit;
  logic w_wait;

  assign w_commit = (r_state == S_COMMIT);
  assign w_wait   = w_mem_en & ~I_mem_ready;

  riscv_mem_perf u_perf (
    .I_clk         (I_clk),
    .I_rst_n       (I_rst_n),
    .I_commit      (w_commit),
    .I_wait        (w_wait),
    .O_instret     (O_instret),
    .O_wait_cycles (O_wait_cycles)
  );
`else
  assign O_instret     = '0;
  assign O_wait_cycles = '0;
`endif

  // Address bits outside the SRAM word range are dropped (aliasing, misalignment)
  logic w_unused;
  assign w_unused = ^{I_imem_addr[31:ADDR_W+2], I_imem_addr[1:0],
                      I_dmem_addr[31:ADDR_W+2], I_dmem_addr[1:0], RESET_PC_WORD};

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_responder.sv
`default_nettype none
// tb_riscv_mem_responder: transaction-level core/SRAM model with per-cycle
// invariant and counter checks plus directed literal checks.
module tb_riscv_mem_responder;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              I_clk = 1'b0;
  logic              I_rst_n = 1'b0;
  logic [31:0]       I_imem_addr = '0;
  logic [31:0]       O_imem_data;
  logic [31:0]       I_dmem_addr = '0;
  logic [31:0]       I_dmem_wdata = '0;
  logic [3:0]        I_dmem_wmask = '0;
  logic              I_dmem_we = 1'b0;
  logic              I_dmem_re = 1'b0;
  logic [31:0]       O_dmem_rdata;
  logic              O_stall;
  logic              O_mem_en;
  logic              O_mem_we;
  logic [ADDR_W-1:0] O_mem_addr;
  logic [3:0]        O_mem_wmask;
  logic [31:0]       O_mem_wdata;
  logic              I_mem_ready = 1'b1;
  logic [31:0]       I_mem_rdata = '0;
  logic [31:0]       O_instret;
  logic [31:0]       O_wait_cycles;

  always #5 I_clk = ~I_clk;

  riscv_mem_responder #(.ADDR_W(ADDR_W), .RESET_PC_WORD(32'd0)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_imem_addr(I_imem_addr), .O_imem_data(O_imem_data),
    .I_dmem_addr(I_dmem_addr), .I_dmem_wdata(I_dmem_wdata),
    .I_dmem_wmask(I_dmem_wmask), .I_dmem_we(I_dmem_we), .I_dmem_re(I_dmem_re),
    .O_dmem_rdata(O_dmem_rdata), .O_stall(O_stall),
    .O_mem_en(O_mem_en), .O_mem_we(O_mem_we), .O_mem_addr(O_mem_addr),
    .O_mem_wmask(O_mem_wmask), .O_mem_wdata(O_mem_wdata),
    .I_mem_ready(I_mem_ready), .I_mem_rdata(I_mem_rdata),
    .O_instret(O_instret), .O_wait_cycles(O_wait_cycles)
  );

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic [31:0]       wdata;
  } acc_t;

  logic [31:0]       mem [DEPTH];
  acc_t              acc_q[$];
  bit                force_q[$];
  bit                rand_ready = 1'b0;
  int                checks = 0;
  int                errors = 0;
  logic [31:0]       m_waits = '0;
  logic [31:0]       m_instret = '0;
  int                inst_waits = 0;
  int                last_cycles = 0;
  logic [31:0]       exp_dmem = '0;
  logic              s_acc = 1'b0;
  logic              s_we = 1'b0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [3:0]        s_mask = '0;
  logic [31:0]       s_wdata = '0;
  logic              prev_wait = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare: invariants, counter model, access log for the SRAM model
  always @(negedge I_clk) begin
    if (!I_rst_n) begin
      m_waits   = '0;
      m_instret = '0;
      s_acc     = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("wait_en_hold", {31'd0, O_mem_en}, 32'd1);
        chk("wait_addr_hold", {18'd0, O_mem_addr}, {18'd0, prev_addr});
      end
      if (O_mem_we) chk("we_without_en", {31'd0, O_mem_en}, 32'd1);
`ifdef RISCV_MEM_PERF_EN
      chk("instret", O_instret, m_instret);
      chk("wait_cycles", O_wait_cycles, m_waits);
`else
      chk("instret_tied", O_instret, 32'd0);
      chk("wait_cycles_tied", O_wait_cycles, 32'd0);
`endif
      if (O_mem_en && !I_mem_ready) begin
        m_waits++;
        inst_waits++;
      end
      if (!O_stall) m_instret++;
      prev_wait = O_mem_en && !I_mem_ready;
      prev_addr = O_mem_addr;
      s_acc     = O_mem_en && I_mem_ready;
      s_we      = O_mem_we;
      s_addr    = O_mem_addr;
      s_mask    = O_mem_wmask;
      s_wdata   = O_mem_wdata;
      if (s_acc) acc_q.push_back('{we: s_we, addr: s_addr, mask: s_mask, wdata: s_wdata});
    end
  end

  // SRAM model: applies accepted writes, returns read data one cycle after accept
  initial begin
    forever begin
      @(posedge I_clk);
      #2;
      if (s_acc && s_we)
        for (int b = 0; b < 4; b++)
          if (s_mask[b]) mem[s_addr][8*b +: 8] = s_wdata[8*b +: 8];
      I_mem_rdata = (s_acc && !s_we) ? mem[s_addr] : $urandom;
      if (force_q.size() > 0) I_mem_ready = force_q.pop_front();
      else if (rand_ready)    I_mem_ready = ($urandom_range(0, 9) < 7);
      else                    I_mem_ready = 1'b1;
    end
  end

  // One instruction from the core's point of view; called just after a clock edge
  task automatic run_instr(input logic [31:0] pc, input logic we, input logic re,
                           input logic [31:0] daddr, input logic [31:0] wdata,
                           input logic [3:0] wmask);
    logic [31:0] exp_ins;
    bit          is_wr, is_rd;
    int          base, cyc;
    acc_t        a;
    I_imem_addr  = pc;
    I_dmem_addr  = daddr;
    I_dmem_wdata = wdata;
    I_dmem_wmask = wmask;
    I_dmem_we    = we;
    I_dmem_re    = re;
    exp_ins = mem[pc[ADDR_W+1:2]];
    is_wr   = we && (wmask != 4'b0000);
    is_rd   = !we && re;
    if (is_rd) exp_dmem = mem[daddr[ADDR_W+1:2]];
    base = is_wr ? 5 : (is_rd ? 6 : 4);
    acc_q.delete();
    inst_waits = 0;
    cyc = 0;
    do begin
      @(negedge I_clk);
      cyc++;
    end while (O_stall && cyc < 200);
    #1;
    if (O_stall) chk("commit_timeout", cyc, 0);
    chk("commit_cycle", cyc, base + inst_waits);
    chk("access_count", acc_q.size(), (is_wr || is_rd) ? 2 : 1);
    if (acc_q.size() > 0)
      chk("fetch_access", {17'd0, acc_q[0].we, acc_q[0].addr}, {17'd0, 1'b0, pc[ADDR_W+1:2]});
    if ((is_wr || is_rd) && acc_q.size() > 1) begin
      a = acc_q[1];
      chk("data_addr", {18'd0, a.addr}, {18'd0, daddr[ADDR_W+1:2]});
      chk("data_we", {31'd0, a.we}, {31'd0, is_wr});
      if (is_wr) begin
        chk("data_wmask", {28'd0, a.mask}, {28'd0, wmask});
        chk("data_wdata", a.wdata, wdata);
      end
    end
    chk("imem_data", O_imem_data, exp_ins);
    chk("dmem_rdata", O_dmem_rdata, exp_dmem);
    last_cycles = cyc;
    @(posedge I_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, O_stall}, 32'd1);
    chk({tag, "_mem_en"}, {31'd0, O_mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, O_mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {18'd0, O_mem_addr}, 32'd0);
    chk({tag, "_imem"}, O_imem_data, 32'h0000_0013);
    chk({tag, "_dmem"}, O_dmem_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] pc;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[4]     = 32'h0050_0093;
    mem[14'h40] = 32'hDEAD_BEEF;

    repeat (3) @(posedge I_clk);
    #1;
    check_reset_outputs("reset");
    I_rst_n  = 1'b1;
    exp_dmem = '0;

    // ALU: addi x1,x0,5 at PC 0x10
    run_instr(32'h10, 1'b0, 1'b0, $urandom, $urandom, 4'hF);
    chk("alu_cycles", last_cycles, 4);
    chk("alu_fetch_addr", {18'd0, acc_q[0].addr}, 32'd4);
    chk("alu_imem", O_imem_data, 32'h0050_0093);

    // Load from 0x100 -> word 0x40
    run_instr(32'h14, 1'b0, 1'b1, 32'h100, $urandom, 4'hF);
    chk("load_cycles", last_cycles, 6);
    chk("load_addr", {18'd0, acc_q[1].addr}, 32'h40);
    chk("load_we", {31'd0, acc_q[1].we}, 32'd0);
    chk("load_rdata", O_dmem_rdata, 32'hDEAD_BEEF);
`ifdef RISCV_MEM_PERF_EN
    chk("instret_after_2", O_instret, 32'd2);
`endif

    // Store byte lane 2 to 0x202 (re also high: write wins)
    run_instr(32'h18, 1'b1, 1'b1, 32'h202, 32'h00AB_0000, 4'b0100);
    chk("store_cycles", last_cycles, 5);
    chk("store_we", {31'd0, acc_q[1].we}, 32'd1);
    chk("store_addr", {18'd0, acc_q[1].addr}, 32'h80);
    chk("store_wmask", {28'd0, acc_q[1].mask}, 32'h4);

    // Store with empty mask: no data access
    run_instr(32'h1C, 1'b1, 1'b0, 32'h300, $urandom, 4'b0000);
    chk("store0_cycles", last_cycles, 4);
    chk("store0_accesses", acc_q.size(), 1);

    // Three fetch wait states
    w0 = O_wait_cycles;
    repeat (3) force_q.push_back(1'b0);
    run_instr(32'h20, 1'b0, 1'b0, $urandom, $urandom, 4'hF);
    chk("wait_cycles_commit", last_cycles, 7);
`ifdef RISCV_MEM_PERF_EN
    chk("wait_counter_delta", O_wait_cycles - w0, 32'd3);
`endif

    // Randomized instruction mix with random SRAM wait states
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      pc = $urandom;
      run_instr(pc, ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom));
    end

    // Reset while the load response is in flight
    rand_ready   = 1'b0;
    I_imem_addr  = 32'h24;
    I_dmem_addr  = 32'h100;
    I_dmem_we    = 1'b0;
    I_dmem_re    = 1'b1;
    repeat (5) @(negedge I_clk);
    chk("pre_reset_stall", {31'd0, O_stall}, 32'd1);
    I_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_dmem = '0;
    repeat (2) @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
    run_instr(32'h28, 1'b0, 1'b0, $urandom, $urandom, 4'hF);
    chk("post_reset_cycles", last_cycles, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Memory-side responder for the RV32I core's imem/dmem ports. The core owns these ports as initiator.
- Serves both the instruction port and the data port from one external single-port synchronous SRAM.
- Holds the core in stall while the fetch and any data access complete, then releases it for exactly one commit cycle per instruction.
- Sits between the core and the SRAM/bus wrapper at SoC top level.

Parameters:
- ADDR_W, 14: SRAM word-address width. Byte address bits [ADDR_W+1:2] are used; higher bits are ignored, so addresses alias by wrap-around.
- RESET_PC_WORD, 0: unused by the responder. Documents that the first fetch comes from whatever address the core presents after reset.

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  reset, asynchronous, active-low
- I_imem_addr  in  32  core PC (byte address)
- O_imem_data  out  32  registered instruction word to core
- I_dmem_addr  in  32  core data byte address
- I_dmem_wdata  in  32  core store data
- I_dmem_wmask  in  4  core byte enables
- I_dmem_we  in  1  store request
- I_dmem_re  in  1  load request (decoded from opcode 0000011 at core top)
- O_dmem_rdata  out  32  registered load word to core
- O_stall  out  1  core stall; low only in the commit cycle
- O_mem_en  out  1  SRAM access request
- O_mem_we  out  1  SRAM write
- O_mem_addr  out  ADDR_W  SRAM word address
- O_mem_wmask  out  4  SRAM byte enables
- O_mem_wdata  out  32  SRAM write data
- I_mem_ready  in  1  SRAM accepts the request in this cycle when O_mem_en=1
- I_mem_rdata  in  32  read data, valid exactly one cycle after an accepted read
- O_instret  out  32  committed-instruction count (optional feature)
- O_wait_cycles  out  32  SRAM wait-state count (optional feature)

Behaviour:
- Reset (async assert, sync release):
  - state=S_FETCH, O_stall=1, O_imem_data=32'h00000013 (NOP), O_dmem_rdata=0.
  - All O_mem_* outputs are 0.
  - Any in-flight SRAM transaction is abandoned. A late rdata is ignored because the state has changed.
- FSM, one state per cycle unless waiting:
  - S_FETCH: O_mem_en=1, we=0, addr=I_imem_addr[ADDR_W+1:2]. Holds until I_mem_ready=1, then goes to S_FETCH_RSP.
  - S_FETCH_RSP: captures I_mem_rdata into O_imem_data, then goes to S_DECIDE.
  - S_DECIDE: the core settles its combinational decode on the new instruction. The responder samples I_dmem_we/I_dmem_re:
    - we=1 with wmask!=0: go to S_DATA (write).
    - we=1 with wmask==0: go to S_COMMIT with no SRAM cycle.
    - else re=1: go to S_DATA (read).
    - else: go to S_COMMIT.
    - we and re both high: write wins and re is ignored.
  - S_DATA: O_mem_en=1, addr=I_dmem_addr[ADDR_W+1:2]. For a write, O_mem_we=1 and wmask/wdata come straight from the core.
    - Holds until ready. A write then goes to S_COMMIT; a read goes to S_DATA_RSP.
    - The core inputs must stay stable while stalled; the responder does not latch them.
  - S_DATA_RSP: captures I_mem_rdata into O_dmem_rdata, then goes to S_COMMIT.
  - S_COMMIT: O_stall=0 for exactly this one cycle, then S_FETCH. The core advances its PC on this edge.
- Latency with zero wait states: ALU/branch 4 cycles, store 5, load 6. Each SRAM wait cycle adds one.
- O_mem_en is low in every state except S_FETCH and S_DATA.
- O_imem_data and O_dmem_rdata change only in their capture states. They stay stable through S_COMMIT and the next fetch.
- Byte lanes are not rotated. The core extracts sub-word loads.
- Misaligned addresses: the low two bits are dropped silently.

Optional Feature:
- Macro RISCV_MEM_PERF_EN.
- When defined:
  - O_instret increments on every S_COMMIT cycle.
  - O_wait_cycles increments every cycle with O_mem_en=1 and I_mem_ready=0.
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package riscv_mem_pkg:
  - State encoding: S_FETCH, S_FETCH_RSP, S_DECIDE, S_DATA, S_DATA_RSP, S_COMMIT.
  - NOP constant 32'h00000013.
  - Load opcode constant 7'b0000011.
- Sub-module riscv_mem_perf holds the two counters. It is instantiated only under RISCV_MEM_PERF_EN.

Test Plan:
- ALU instruction: hold ready=1, I_imem_addr=0x10, rdata=0x00500093 (addi x1,x0,5).
  - O_mem_addr=4.
  - O_imem_data=0x00500093 two cycles after S_FETCH entry.
  - O_stall low exactly on cycle 4, with no data SRAM cycle.
- Load: SRAM word 0x40 holds 0xDEADBEEF, dmem_addr=0x100, re=1.
  - Second SRAM access uses addr=0x40 and we=0.
  - O_dmem_rdata=0xDEADBEEF; stall low on cycle 6.
- Store: we=1, wmask=4'b0100, wdata=0x00AB0000, addr=0x202.
  - O_mem_we=1, addr=0x80, wmask=4'b0100.
  - Commit on cycle 5.
- Store with wmask=0: there is no second O_mem_en pulse, and commit is on cycle 4.
- Wait states:
  - I_mem_ready held low for 3 cycles in S_FETCH: address stable throughout; commit delayed to cycle 7; O_wait_cycles=3 with RISCV_MEM_PERF_EN.
  - After 2 instructions: O_instret=2.
- Reset mid-load: drop I_rst_n while in S_DATA_RSP.
  - Immediately (asynchronously) O_stall=1, O_mem_en=0, O_imem_data=0x00000013, O_dmem_rdata=0.
  - After release, the first action is a fetch.
